seq_detector_param: RTL

//   Parametrised serial pattern detector. It is the generalised successor of the

---
 rtl/seq_detector_param.sv | 102 ++++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with a runtime-loadable pattern.
// Define SEQ_DET_CNT_EN to build the saturating match counter.
module seq_detector_param #(
   parameter int unsigned      PAT_W   = 4,
   parameter logic [PAT_W-1:0] PAT_RST = 4'b0110,
   parameter int unsigned      CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             a,
   input  logic             overlap,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   output logic             b,
   output logic             b_q,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int unsigned FW = $clog2(PAT_W);
   localparam logic [FW-1:0] FULL_CNT = FW'(PAT_W - 1);

   typedef enum logic [1:0] {
      S_EMPTY,
      S_FILLING,
      S_FULL
   } fill_st_t;

   fill_st_t         r_st;
   fill_st_t         w_st_nxt;
   logic [FW-1:0]    r_fill;
   logic [FW-1:0]    w_fill_nxt;
   logic [PAT_W-2:0] r_hist;
   logic [PAT_W-2:0] w_hist_nxt;
   logic [PAT_W-1:0] r_pat;
   logic [PAT_W-1:0] w_pat_nxt;
   logic [PAT_W-1:0] w_shift;
   logic             w_b;
   logic             r_b_q;

   assign w_shift = {r_hist, a};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_st   <= S_EMPTY;
         r_fill <= '0;
         r_hist <= '0;
         r_pat  <= PAT_RST;
         r_b_q  <= 1'b0;
      end else begin
         r_st   <= w_st_nxt;
         r_fill <= w_fill_nxt;
         r_hist <= w_hist_nxt;
         r_pat  <= w_pat_nxt;
         r_b_q  <= w_b;
      end
   end

   always_comb begin
      w_st_nxt   = r_st;
      w_fill_nxt = r_fill;
      w_hist_nxt = r_hist;
      w_pat_nxt  = r_pat;
      w_b        = en & ~pat_load & ~reset
                 & (r_st == S_FULL) & (w_shift == r_pat);
      if (pat_load) begin
         w_pat_nxt  = pat_in;
         w_fill_nxt = '0;
         w_st_nxt   = S_EMPTY;
      end else if (en) begin
         w_hist_nxt = w_shift[PAT_W-2:0];
         if (w_b && !overlap) begin
            // non-overlapping: the matched bits cannot seed the next match
            w_fill_nxt = '0;
            w_st_nxt   = S_EMPTY;
         end else if (r_st != S_FULL) begin
            w_fill_nxt = r_fill + 1'b1;
            w_st_nxt   = (r_fill == FULL_CNT - 1'b1) ? S_FULL : S_FILLING;
         end
      end
   end

   assign b   = w_b;
   assign b_q = r_b_q;

`ifdef SEQ_DET_CNT_EN
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_b && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign match_cnt = r_cnt;
`else
   assign match_cnt = '0;
`endif

endmodule
